ahbl2nmi_wbuf: RTL and testbench

- Parametrised successor to the single-transfer AHB-Lite-to-NMI bridge placed between a user core's AHB-Lite master port and the SoC native memory interface (NMI).
- Adds a posted-write FIFO of configurable depth, which gives zero-wait writes when the FIFO is not full.
- Reads are strictly ordered behind buffered writes.
- Address width and buffer depth are configurable.

---
 rtl/ahbl2nmi_wbuf.sv | 183 ++++++++++++++++++
 tb/tb_ahbl2nmi_wbuf.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl2nmi_wbuf.sv
// ahbl2nmi_wbuf: AHB-Lite slave to NMI master bridge with a posted-write FIFO.
// Writes are acknowledged with zero wait while the FIFO has room; reads wait
// until every buffered write has reached the NMI, then issue one NMI read.
// Optional macro AHBL2NMI_WBUF_ERR_EN: reject bad sizes and misaligned
// transfers with a two-cycle AHB ERROR instead of force-aligning them.
module ahbl2nmi_wbuf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [31:0]           hwdata_i,
  output logic                  hready_o,
  output logic                  hresp_o,
  output logic [31:0]           hrdata_o,
  output logic                  nmi_valid_o,
  input  logic                  nmi_ready_i,
  output logic [ADDR_WIDTH-1:0] nmi_addr_o,
  output logic [31:0]           nmi_wdata_o,
  output logic [3:0]            nmi_wstrb_o,
  input  logic [31:0]           nmi_rdata_i,
  output logic [LVL_W-1:0]      wbuf_level_o,
  output logic                  wbuf_empty_o
);

  localparam int                PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0]  FULL_L = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_P = PTR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, RD_WAIT, RD_REQ, RD_RESP, ERR1, ERR2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_strb;
  logic [31:0]           r_hrdata;
  logic [LVL_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [ADDR_WIDTH-1:0] r_fa [DEPTH];
  logic [31:0]           r_fd [DEPTH];
  logic [3:0]            r_fs [DEPTH];

  logic                  w_hready;
  logic                  w_cap;
  logic                  w_full;
  logic                  w_push;
  logic                  w_drain;
  logic                  w_pop;
  logic                  w_err;
  logic                  w_rd_go;
  logic [3:0]            w_strb;
  logic [LVL_W-1:0]      w_count_nxt;

  assign w_full  = (r_count == FULL_L);
  assign w_cap   = htrans_i[1] & w_hready;
  assign w_push  = (r_state == WR_DATA) & ~w_full;
  // The FIFO owns the NMI whenever a read is not actively requesting it.
  assign w_drain = (r_state != RD_REQ) & (r_count != '0);
  assign w_pop   = w_drain & nmi_ready_i;
  // A read may request the NMI once the FIFO will be empty after this edge.
  assign w_rd_go = (w_count_nxt == '0);

`ifdef AHBL2NMI_WBUF_ERR_EN
  assign w_err   = (hsize_i > 3'd2) |
                   ((hsize_i == 3'd1) & haddr_i[0]) |
                   ((hsize_i == 3'd2) & (haddr_i[1:0] != 2'b00));
  assign hresp_o = (r_state == ERR1) | (r_state == ERR2);
`else
  assign w_err   = 1'b0;
  assign hresp_o = 1'b0;
`endif

  assign hrdata_o     = r_hrdata;
  assign hready_o     = w_hready;
  assign wbuf_level_o = r_count;
  assign wbuf_empty_o = (r_count == '0);

  // Byte strobes from size and low address; oversize and misaligned are forced to natural alignment.
  always_comb begin
    case (hsize_i)
      3'd0:    w_strb = 4'b0001 << haddr_i[1:0];
      3'd1:    w_strb = 4'b0011 << {haddr_i[1], 1'b0};
      default: w_strb = 4'b1111;
    endcase
  end

  // Data-phase ready derived from the registered state and FIFO count.
  always_comb begin
    case (r_state)
      WR_DATA:                w_hready = ~w_full;
      RD_WAIT, RD_REQ, ERR1:  w_hready = 1'b0;
      default:                w_hready = 1'b1;
    endcase
  end

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  // NMI request mux: pending read first, otherwise the FIFO head.
  always_comb begin
    nmi_valid_o = 1'b0;
    nmi_addr_o  = '0;
    nmi_wdata_o = '0;
    nmi_wstrb_o = '0;
    if (r_state == RD_REQ) begin
      nmi_valid_o = 1'b1;
      nmi_addr_o  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    end else if (r_count != '0) begin
      nmi_valid_o = 1'b1;
      nmi_addr_o  = r_fa[r_rptr];
      nmi_wdata_o = r_fd[r_rptr];
      nmi_wstrb_o = r_fs[r_rptr];
    end
  end

  // Transfer FSM: address-phase capture, data-phase sequencing and read data latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_strb   <= '0;
      r_hrdata <= '0;
    end else begin
      if (w_cap) begin
        r_addr <= haddr_i;
        r_strb <= w_strb;
      end
      if (w_hready) begin
        if (!w_cap)        r_state <= IDLE;
        else if (w_err)    r_state <= ERR1;
        else if (hwrite_i) r_state <= WR_DATA;
        else if (w_rd_go)  r_state <= RD_REQ;
        else               r_state <= RD_WAIT;
      end else begin
        case (r_state)
          RD_WAIT: if (w_rd_go) r_state <= RD_REQ;
          RD_REQ: begin
            if (nmi_ready_i) begin
              r_hrdata <= nmi_rdata_i;
              r_state  <= RD_RESP;
            end
          end
          ERR1:    r_state <= ERR2;
          default: ;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; reset flushes everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wptr <= (r_wptr == LAST_P) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LAST_P) ? '0 : r_rptr + 1'b1;
    end
  end

  // FIFO storage; entries carry the word-aligned address.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fa[r_wptr] <= {r_addr[ADDR_WIDTH-1:2], 2'b00};
      r_fd[r_wptr] <= hwdata_i;
      r_fs[r_wptr] <= r_strb;
    end
  end

endmodule

// File: tb/tb_ahbl2nmi_wbuf.sv
// Bench for ahbl2nmi_wbuf: directed scenarios plus randomized AHB traffic,
// checked every cycle against a queue-based transaction model.
`timescale 1ns/1ps
module tb_ahbl2nmi_wbuf;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] haddr_i;
  logic [1:0]    htrans_i;
  logic          hwrite_i;
  logic [2:0]    hsize_i;
  logic [31:0]   hwdata_i;
  logic          hready_o, hresp_o;
  logic [31:0]   hrdata_o;
  logic          nmi_valid_o, nmi_ready_i;
  logic [AW-1:0] nmi_addr_o;
  logic [31:0]   nmi_wdata_o;
  logic [3:0]    nmi_wstrb_o;
  logic [31:0]   nmi_rdata_i;
  logic [LW-1:0] wbuf_level_o;
  logic          wbuf_empty_o;

  always #5 clk = ~clk;

  ahbl2nmi_wbuf #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .haddr_i(haddr_i), .htrans_i(htrans_i),
    .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hwdata_i(hwdata_i),
    .hready_o(hready_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o),
    .nmi_valid_o(nmi_valid_o), .nmi_ready_i(nmi_ready_i), .nmi_addr_o(nmi_addr_o),
    .nmi_wdata_o(nmi_wdata_o), .nmi_wstrb_o(nmi_wstrb_o), .nmi_rdata_i(nmi_rdata_i),
    .wbuf_level_o(wbuf_level_o), .wbuf_empty_o(wbuf_empty_o)
  );

  int total = 0;
  int bad   = 0;
  bit rnd   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } ent_t;
  ent_t        q[$];
  int          dk = 0;      // current data phase: 0 none, 1 write, 2 read, 3 error
  int          ph = 0;      // read: 0 draining, 1 requesting, 2 done; error: 0 first, 1 second
  logic [31:0] da = '0;
  logic [3:0]  ds = '0;
  logic [31:0] m_rd = '0;
  bit          mvalid = 1'b0;

  function automatic logic [3:0] strb_of(input logic [2:0] sz, input logic [1:0] a);
    if (sz == 3'd0) begin
      case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit bad_of(input logic [2:0] sz, input logic [1:0] a);
`ifdef AHBL2NMI_WBUF_ERR_EN
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a != 2'b00);
`else
    return 1'b0 & (^{sz, a});
`endif
  endfunction

  function automatic bit e_hready();
    case (dk)
      0:       return 1'b1;
      1:       return q.size() < DEPTH;
      2:       return ph == 2;
      default: return ph == 1;
    endcase
  endfunction

  // Compare on the falling edge, then advance the model with the inputs the DUT samples next.
  always @(negedge clk) begin : mdl
    bit   hr, rq, dopop, dopush;
    ent_t e;
    rq = (dk == 2 && ph == 1);
    if (mvalid) begin
      check("hready", 32'(hready_o), 32'(e_hready()));
      check("hresp", 32'(hresp_o), 32'(dk == 3));
      check("hrdata", hrdata_o, m_rd);
      check("level", 32'(wbuf_level_o), 32'(q.size()));
      check("empty", 32'(wbuf_empty_o), 32'(q.size() == 0));
      if (rq) begin
        check("nvalid_rd", 32'(nmi_valid_o), 1);
        check("naddr_rd", nmi_addr_o, {da[31:2], 2'b00});
        check("nstrb_rd", 32'(nmi_wstrb_o), 0);
      end else if (q.size() > 0) begin
        check("nvalid_wr", 32'(nmi_valid_o), 1);
        check("naddr_wr", nmi_addr_o, q[0].a);
        check("ndata_wr", nmi_wdata_o, q[0].d);
        check("nstrb_wr", 32'(nmi_wstrb_o), 32'(q[0].s));
      end else begin
        check("nvalid_idle", 32'(nmi_valid_o), 0);
      end
    end
    if (rst_i) begin
      q.delete(); dk = 0; ph = 0; m_rd = '0; mvalid = 1'b1;
    end else if (mvalid) begin
      hr     = e_hready();
      dopop  = !rq && q.size() > 0 && nmi_ready_i;
      dopush = (dk == 1) && q.size() < DEPTH;
      if (dopop) void'(q.pop_front());
      if (dopush) begin
        e.a = {da[31:2], 2'b00}; e.d = hwdata_i; e.s = ds;
        q.push_back(e);
      end
      if (rq && nmi_ready_i) begin m_rd = nmi_rdata_i; ph = 2; end
      else if (dk == 2 && ph == 0 && q.size() == 0) ph = 1;
      else if (dk == 3 && ph == 0) ph = 1;
      if (hr) begin
        if (!htrans_i[1]) dk = 0;
        else begin
          da = haddr_i;
          ds = strb_of(hsize_i, haddr_i[1:0]);
          if (bad_of(hsize_i, haddr_i[1:0])) begin dk = 3; ph = 0; end
          else if (hwrite_i) dk = 1;
          else begin dk = 2; ph = (q.size() == 0) ? 1 : 0; end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Present one address phase and return once it has been accepted; data follows.
  task automatic xfer(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    logic h;
    int   n;
    htrans_i = tr; hwrite_i = wr; haddr_i = a; hsize_i = sz; n = 0;
    forever begin
      @(negedge clk); h = hready_o;
      @(posedge clk); #1;
      if (rnd) begin
        nmi_ready_i = 1'($urandom_range(0, 1));
        nmi_rdata_i = $urandom;
      end
      if (h === 1'b1) break;
      n++;
      if (n > 300) begin check("xfer_timeout", 32'(hready_o), 1); break; end
    end
    hwdata_i = wd;
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (wbuf_empty_o === 1'b1 && hready_o === 1'b1) break;
      n++;
      if (n > 300) begin check("drain_timeout", 32'(wbuf_empty_o), 1); break; end
    end
    cyc();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] tr;
    logic [2:0] sz;
    htrans_i = 2'b00; hwrite_i = 1'b0; haddr_i = '0; hsize_i = 3'd0; hwdata_i = '0;
    nmi_ready_i = 1'b0; nmi_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // reset values held through 10 idle cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_hready", 32'(hready_o), 1);
      check("idle_hresp", 32'(hresp_o), 0);
      check("idle_hrdata", hrdata_o, 0);
      check("idle_nvalid", 32'(nmi_valid_o), 0);
      check("idle_naddr", nmi_addr_o, 0);
      check("idle_nwstrb", 32'(nmi_wstrb_o), 0);
      check("idle_level", 32'(wbuf_level_o), 0);
      check("idle_empty", 32'(wbuf_empty_o), 1);
    end
    cyc();

    // fill the FIFO with NMI stalled; the fifth write waits for the first pop
    for (int i = 0; i < 5; i++) xfer(2'b10, 1'b1, 32'h100 + 32'(i * 4), 3'd2, 32'h1000 + 32'(i));
    htrans_i = 2'b00;
    @(negedge clk);
    check("fill_level", 32'(wbuf_level_o), 4);
    check("fill_stall", 32'(hready_o), 0);
    check("fill_model", 32'(q.size()), 4);
    cyc(); cyc();
    nmi_ready_i = 1'b1;
    @(negedge clk);
    check("first_pop_addr", nmi_addr_o, 32'h100);
    check("w5_wait", 32'(hready_o), 0);
    cyc();
    @(negedge clk);
    check("w5_done", 32'(hready_o), 1);
    cyc();
    drain();

    // byte write then read: write reaches NMI first, read has one wait once empty
    nmi_rdata_i = 32'hDEADBEEF;
    xfer(2'b10, 1'b1, 32'h203, 3'd0, 32'hAB000000);
    xfer(2'b10, 1'b0, 32'h200, 3'd2, 32'h0);
    htrans_i = 2'b00;
    @(negedge clk);
    check("bw_nvalid", 32'(nmi_valid_o), 1);
    check("bw_nstrb", 32'(nmi_wstrb_o), 32'h8);
    check("bw_naddr", nmi_addr_o, 32'h200);
    check("bw_ndata", nmi_wdata_o, 32'hAB000000);
    check("bw_rd_wait", 32'(hready_o), 0);
    cyc();
    @(negedge clk);
    check("rd_nvalid", 32'(nmi_valid_o), 1);
    check("rd_nstrb", 32'(nmi_wstrb_o), 0);
    check("rd_naddr", nmi_addr_o, 32'h200);
    check("rd_wait1", 32'(hready_o), 0);
    cyc();
    @(negedge clk);
    check("rd_done", 32'(hready_o), 1);
    check("rd_data", hrdata_o, 32'hDEADBEEF);
    check("rd_model", m_rd, 32'hDEADBEEF);
    cyc();

    // half write to 0x302
    nmi_ready_i = 1'b0;
    xfer(2'b10, 1'b1, 32'h302, 3'd1, 32'h5A5A0000);
    htrans_i = 2'b00;
    @(negedge clk);
    cyc();
    @(negedge clk);
    check("hw_nvalid", 32'(nmi_valid_o), 1);
    check("hw_naddr", nmi_addr_o, 32'h300);
    check("hw_nstrb", 32'(nmi_wstrb_o), 32'hC);
    cyc();
    nmi_ready_i = 1'b1;
    drain();

    // misaligned word read at 0x401
    nmi_rdata_i = 32'h0BADF00D;
    xfer(2'b10, 1'b0, 32'h401, 3'd2, 32'h0);
    htrans_i = 2'b00;
    @(negedge clk);
`ifdef AHBL2NMI_WBUF_ERR_EN
    check("err1_hready", 32'(hready_o), 0);
    check("err1_hresp", 32'(hresp_o), 1);
    check("err1_nvalid", 32'(nmi_valid_o), 0);
    cyc();
    @(negedge clk);
    check("err2_hready", 32'(hready_o), 1);
    check("err2_hresp", 32'(hresp_o), 1);
    check("err2_nvalid", 32'(nmi_valid_o), 0);
`else
    check("mis_nvalid", 32'(nmi_valid_o), 1);
    check("mis_naddr", nmi_addr_o, 32'h400);
    check("mis_nstrb", 32'(nmi_wstrb_o), 0);
    cyc();
    @(negedge clk);
    check("mis_done", 32'(hready_o), 1);
    check("mis_data", hrdata_o, 32'h0BADF00D);
    check("mis_hresp", 32'(hresp_o), 0);
`endif
    cyc();

    // reset with three writes buffered and the NMI request pending
    nmi_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) xfer(2'b10, 1'b1, 32'h500 + 32'(i * 4), 3'd2, 32'h77 + 32'(i));
    htrans_i = 2'b00;
    cyc();
    @(negedge clk);
    check("pre_rst_level", 32'(wbuf_level_o), 3);
    check("pre_rst_nvalid", 32'(nmi_valid_o), 1);
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_nvalid", 32'(nmi_valid_o), 0);
    check("rst_level", 32'(wbuf_level_o), 0);
    check("rst_hready", 32'(hready_o), 1);
    check("rst_empty", 32'(wbuf_empty_o), 1);
    cyc();

    // randomized traffic with random NMI back-pressure
    rnd = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tr = ($urandom_range(0, 2) != 0) ? 2'b10 : 2'b00;
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      xfer(tr, 1'($urandom_range(0, 1)), 32'h1000 + ($urandom & 32'hFF), sz, $urandom);
    end
    rnd = 1'b0;
    htrans_i = 2'b00;
    nmi_ready_i = 1'b1;
    drain();
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
